// File: rtl/dpram2.sv
// dpram2: single-clock true dual-port RAM with byte enables, RDW mode,
// optional output register, read-valid strobes and clear-on-reset engine.
// Ports: clock, reset (sync, active-high), busy; per port X in {a,b}:
//   ce_x, wren_x, byteena_x, address_x, data_x -> q_x, valid_x.
// Optional macro DPRAM2_COLLISION_CNT_EN adds output collisions[15:0].
module dpram2 #(
  parameter int width_a = 16,
  parameter int widthad_a = 10,
  parameter string init_file = "",
  parameter string RDW_MODE = "NEW",
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [width_a-1:0] CLEAR_VALUE = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   busy,
  input  logic                   ce_a,
  input  logic                   wren_a,
  input  logic [width_a/8-1:0]   byteena_a,
  input  logic [widthad_a-1:0]   address_a,
  input  logic [width_a-1:0]     data_a,
  output logic [width_a-1:0]     q_a,
  output logic                   valid_a,
  input  logic                   ce_b,
  input  logic                   wren_b,
  input  logic [width_a/8-1:0]   byteena_b,
  input  logic [widthad_a-1:0]   address_b,
  input  logic [width_a-1:0]     data_b,
  output logic [width_a-1:0]     q_b,
  output logic                   valid_b
`ifdef DPRAM2_COLLISION_CNT_EN
  ,output logic [15:0]           collisions
`endif
);

  localparam int NB = width_a / 8;
  localparam int DEPTH = 1 << widthad_a;
  localparam int CW = widthad_a + 1;
  localparam bit RDW_OLD = (RDW_MODE == "OLD");

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  logic [width_a-1:0] mem [DEPTH];

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;

  // Clear engine: restarts from address 0 on every reset cycle.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    if (reset) begin
      state_d = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt_d = '0;
      busy_d = (CLEAR_ON_RESET != 0);
    end else if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DEPTH - 1)) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    busy_q <= busy_d;
  end

  assign busy = busy_q;

  logic clr_we;
  logic acc_a, acc_b;
  logic [NB-1:0] we_a, we_b;
  logic [width_a-1:0] rd_a, rd_b, nw_a, nw_b;

  assign clr_we = !reset && (state_q == S_CLEAR);
  assign acc_a = ce_a && !busy_q && !reset;
  assign acc_b = ce_b && !busy_q && !reset;
  assign we_a = {NB{acc_a & wren_a}} & byteena_a;
  assign we_b = {NB{acc_b & wren_b}} & byteena_b;

  // Both reads see pre-edge contents, so cross-port reads return old data.
  assign rd_a = mem[address_a];
  assign rd_b = mem[address_b];

  always_comb begin
    nw_a = rd_a;
    nw_b = rd_b;
    for (int l = 0; l < NB; l++) begin
      if (we_a[l]) nw_a[l*8 +: 8] = data_a[l*8 +: 8];
      if (we_b[l]) nw_b[l*8 +: 8] = data_b[l*8 +: 8];
    end
  end

  // Port B lanes are written first so port A wins on shared lanes.
  always_ff @(posedge clock) begin
    if (clr_we) mem[cnt_q[widthad_a-1:0]] <= CLEAR_VALUE;
    for (int l = 0; l < NB; l++) begin
      if (we_b[l]) mem[address_b][l*8 +: 8] <= data_b[l*8 +: 8];
      if (we_a[l]) mem[address_a][l*8 +: 8] <= data_a[l*8 +: 8];
    end
  end

  logic [width_a-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d;
  logic v1_a_q, v1_a_d, v1_b_q, v1_b_d;

  always_comb begin
    q1_a_d = q1_a_q;
    q1_b_d = q1_b_q;
    v1_a_d = acc_a;
    v1_b_d = acc_b;
    if (acc_a) q1_a_d = RDW_OLD ? rd_a : nw_a;
    if (acc_b) q1_b_d = RDW_OLD ? rd_b : nw_b;
    if (reset) begin
      q1_a_d = '0;
      q1_b_d = '0;
      v1_a_d = 1'b0;
      v1_b_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    q1_a_q <= q1_a_d;
    q1_b_q <= q1_b_d;
    v1_a_q <= v1_a_d;
    v1_b_q <= v1_b_d;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [width_a-1:0] q2_a_q, q2_a_d, q2_b_q, q2_b_d;
    logic v2_a_q, v2_a_d, v2_b_q, v2_b_d;

    always_comb begin
      q2_a_d = v1_a_q ? q1_a_q : q2_a_q;
      q2_b_d = v1_b_q ? q1_b_q : q2_b_q;
      v2_a_d = v1_a_q;
      v2_b_d = v1_b_q;
      if (reset) begin
        q2_a_d = '0;
        q2_b_d = '0;
        v2_a_d = 1'b0;
        v2_b_d = 1'b0;
      end
    end

    always_ff @(posedge clock) begin
      q2_a_q <= q2_a_d;
      q2_b_q <= q2_b_d;
      v2_a_q <= v2_a_d;
      v2_b_q <= v2_b_d;
    end

    assign q_a = q2_a_q;
    assign q_b = q2_b_q;
    assign valid_a = v2_a_q;
    assign valid_b = v2_b_q;
  end else begin : g_noreg
    assign q_a = q1_a_q;
    assign q_b = q1_b_q;
    assign valid_a = v1_a_q;
    assign valid_b = v1_b_q;
  end

`ifdef DPRAM2_COLLISION_CNT_EN
  logic [15:0] col_q, col_d;
  logic coll_ev;

  assign coll_ev = acc_a && acc_b && (address_a == address_b)
                   && (wren_a || wren_b);

  always_comb begin
    col_d = col_q;
    if (reset) col_d = '0;
    else if (coll_ev && col_q != 16'hFFFF) col_d = col_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    col_q <= col_d;
    if (coll_ev) $display("dpram2 collision: %0h", address_a);
  end

  assign collisions = col_q;
`endif

endmodule
